// File: rtl/gpio_in_debounce_irq.sv
// GPIO input conditioning: 2-FF sync, tick-sampled debounce, edge detect, W1C pending, level irq.
// Latency: pin_state 2 clk + DB_COUNT ticks; pending +1 clk; irq +1 clk. No backpressure; inputs always accepted.
module gpio_in_debounce_irq #(
    parameter int WIDTH    = 8,
    parameter int TICK_DIV = 50000,
    parameter int DB_COUNT = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_pin_in,
    input  logic [WIDTH-1:0] i_rise_en,
    input  logic [WIDTH-1:0] i_fall_en,
    input  logic [WIDTH-1:0] i_irq_en,
    input  logic [WIDTH-1:0] i_pend_clr,
    output logic [WIDTH-1:0] o_pin_state,
    output logic [WIDTH-1:0] o_pending,
    output logic             o_irq,
    output logic             o_sample_tick
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = $clog2(DB_COUNT + 1);
    localparam logic [PW-1:0] DIV_LAST = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_COUNT - 1);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_pin_state;
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_pending;
    logic             r_irq;
    logic [PW-1:0]    r_div;
    logic [CW-1:0]    r_cnt [WIDTH];

    logic             w_tick;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;

    assign w_tick = (r_div == DIV_LAST);
    assign w_rise = r_pin_state & ~r_prev;
    assign w_fall = ~r_pin_state & r_prev;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= i_pin_in;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_div <= '0;
        end else if (w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    // A matching sample restarts the run, so glitches shorter than DB_COUNT ticks never reach pin_state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pin_state <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else if (w_tick) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (r_sync2[i] == r_pin_state[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_LAST) begin
                    r_pin_state[i] <= r_sync2[i];
                    r_cnt[i]       <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Set terms are OR'd after the clear so a same-cycle edge is never lost.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_prev    <= '0;
            r_pending <= '0;
            r_irq     <= 1'b0;
        end else begin
            r_prev    <= r_pin_state;
            r_pending <= (r_pending & ~i_pend_clr) | (w_rise & i_rise_en) | (w_fall & i_fall_en);
            r_irq     <= |(r_pending & i_irq_en);
        end
    end

    assign o_pin_state   = r_pin_state;
    assign o_pending     = r_pending;
    assign o_irq         = r_irq;
    assign o_sample_tick = w_tick;

endmodule

// File: tb/tb_gpio_in_debounce_irq.sv
// Bench for gpio_in_debounce_irq: reference model pushes expected outputs per clk, monitor pops and compares.
module tb_gpio_in_debounce_irq;

    localparam int W  = 4;
    localparam int TD = 4;
    localparam int DB = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] pin_in, rise_en, fall_en, irq_en, pend_clr;
    logic [W-1:0] pin_state, pending;
    logic         irq, sample_tick;

    always #5 clk = ~clk;

    gpio_in_debounce_irq #(.WIDTH(W), .TICK_DIV(TD), .DB_COUNT(DB)) dut (
        .i_clk(clk), .i_rst(rst), .i_pin_in(pin_in), .i_rise_en(rise_en),
        .i_fall_en(fall_en), .i_irq_en(irq_en), .i_pend_clr(pend_clr),
        .o_pin_state(pin_state), .o_pending(pending), .o_irq(irq),
        .o_sample_tick(sample_tick)
    );

    typedef struct packed {
        logic [W-1:0] ps;
        logic [W-1:0] pend;
        logic         irq;
        logic         tick;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model state
    logic [W-1:0]  hist[$];
    logic [W-1:0]  m_ps_now, m_ps_prev, m_pend, m_sync, m_new_ps;
    logic          m_irq, m_new_irq, m_tick_now;
    logic [DB-1:0] m_smp [W];
    int            m_nsmp [W];
    int            m_edges;
    exp_t          m_e;

    always @(posedge clk) begin
        if (rst) begin
            hist.delete();
            hist.push_back('0);
            hist.push_back('0);
            m_ps_now = '0; m_ps_prev = '0; m_pend = '0; m_irq = 1'b0; m_edges = 0;
            for (int i = 0; i < W; i++) begin
                m_smp[i] = '0;
                m_nsmp[i] = 0;
            end
        end else begin
            m_sync = hist.pop_front();
            hist.push_back(pin_in);
            m_tick_now = ((m_edges % TD) == TD - 1);
            m_edges++;
            m_new_irq = |(m_pend & irq_en);
            m_pend = (m_pend & ~pend_clr)
                   | (m_ps_now & ~m_ps_prev & rise_en)
                   | (~m_ps_now & m_ps_prev & fall_en);
            m_new_ps = m_ps_now;
            if (m_tick_now) begin
                for (int i = 0; i < W; i++) begin
                    m_smp[i] = {m_smp[i][DB-2:0], m_sync[i]};
                    if (m_nsmp[i] < DB) m_nsmp[i]++;
                    // accept once the last DB tick samples all disagree with the current level
                    if (m_nsmp[i] >= DB && m_smp[i] == {DB{~m_ps_now[i]}})
                        m_new_ps[i] = m_sync[i];
                end
            end
            m_ps_prev = m_ps_now;
            m_ps_now  = m_new_ps;
            m_irq     = m_new_irq;
        end
        m_e.ps   = m_ps_now;
        m_e.pend = m_pend;
        m_e.irq  = m_irq;
        m_e.tick = rst ? 1'b0 : ((m_edges % TD) == TD - 1);
        exp_q.push_back(m_e);
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at %0t: got=%b expected=%b", name, $time, act, expv);
        end
    endtask

    exp_t mon_e;
    always @(posedge clk) begin
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty at %0t: got=0 entries expected>=1", $time);
        end else begin
            mon_e = exp_q.pop_front();
            check("pin_state",   pin_state,         mon_e.ps);
            check("pending",     pending,           mon_e.pend);
            check("irq",         {3'b0, irq},         {3'b0, mon_e.irq});
            check("sample_tick", {3'b0, sample_tick}, {3'b0, mon_e.tick});
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rand_segments(input int nseg);
        int len;
        for (int s = 0; s < nseg; s++) begin
            pin_in  = W'($urandom);
            rise_en = W'($urandom);
            fall_en = W'($urandom);
            irq_en  = W'($urandom);
            len     = $urandom_range(1, 40);
            for (int c = 0; c < len; c++) begin
                pend_clr = ($urandom_range(0, 3) == 0) ? W'($urandom) : '0;
                cyc(1);
            end
            pend_clr = '0;
        end
    endtask

    initial begin
        rst = 1'b1; pin_in = 4'b0101;
        rise_en = '0; fall_en = '0; irq_en = '0; pend_clr = '0;
        cyc(3);
        rst = 1'b0;
        cyc(30);
        pend_clr = 4'hF; cyc(1); pend_clr = '0;
        pin_in = 4'b0000; cyc(30);
        pend_clr = 4'hF; cyc(1); pend_clr = '0;
        // rising edge on pin 0 with irq, then W1C
        rise_en = 4'b0001; irq_en = 4'b0001;
        pin_in = 4'b0001; cyc(30);
        pend_clr = 4'b0001; cyc(1); pend_clr = '0; cyc(5);
        // two-tick glitch on pin 1
        pin_in = 4'b0011; cyc(8);
        pin_in = 4'b0001; cyc(30);
        // masked falling edge on pin 2, then unmask
        pin_in = 4'b0101; cyc(30);
        fall_en = 4'b0100;
        pin_in = 4'b0001; cyc(30);
        irq_en = 4'b0101; cyc(5);
        pend_clr = 4'hF; cyc(1); pend_clr = '0;
        // clear held across a new rise on pin 0
        pin_in = 4'b0000; cyc(30);
        pend_clr = 4'b0001;
        pin_in = 4'b0001; cyc(30);
        pend_clr = '0; cyc(5);
        rand_segments(40);
        rst = 1'b1; pin_in = W'($urandom); cyc(2);
        rst = 1'b0;
        rand_segments(25);
        cyc(3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
